imem_load_ctrl: RTL

Sequencing controller for the single-port instruction memory. Owns the memory port and time-shares it between a host program loader, which clears the memory and then streams words in, and the CPU fetch stage, which reads instructions by PC. Holds the CPU in stall until a program has been loaded and pulses a start strobe when it may begin fetching.

---
 rtl/imem_load_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/imem_load_ctrl.sv
// Instruction-memory port sequencer: clears the memory, streams a program in from the
// host loader, then hands the port to the CPU fetch stage.
module imem_load_ctrl #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic [ADDR_W:0]   load_len,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    output logic              ld_ready,
    input  logic              fetch_en,
    input  logic [31:0]       cpu_pc,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              cpu_stall,
    output logic              cpu_start,
    output logic              busy,
    output logic              err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned     CntW     = ADDR_W + 1;
    localparam logic [ADDR_W:0] DepthLen = CntW'(DEPTH);
    localparam logic [ADDR_W:0] LastAddr = CntW'(DEPTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StLoad,
        StRun
    } state_e;

    state_e          state_q, state_d;
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic [ADDR_W:0] len_q, len_d;
    logic            err_q, err_d;
    logic            ivalid_q, ivalid_d;
    logic            start_q, start_d;

    logic [ADDR_W:0] len_clamped;
    logic [ADDR_W:0] cnt_inc;
    logic            pc_bad;

    assign len_clamped = (load_len > DepthLen) ? DepthLen : load_len;
    assign cnt_inc     = cnt_q + CntW'(1);

    // Misaligned, or beyond the memory; the fetch still uses the truncated word index.
    assign pc_bad = (cpu_pc[1:0] != 2'b00) || ((cpu_pc >> (ADDR_W + 2)) != 32'd0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        err_d     = err_q;
        ivalid_d  = 1'b0;
        start_d   = 1'b0;
        ld_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            StIdle: begin
                if (load_req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                    len_d   = len_clamped;
                    err_d   = 1'b0;
                end
            end

            StClear: begin
                mem_we   = 1'b1;
                mem_addr = cnt_q[ADDR_W-1:0];
                if (cnt_q == LastAddr) begin
                    cnt_d = '0;
                    if (len_q == '0) begin
                        state_d = StRun;
                        start_d = 1'b1;
                    end else begin
                        state_d = StLoad;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            StLoad: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    mem_we    = 1'b1;
                    mem_addr  = cnt_q[ADDR_W-1:0];
                    mem_wdata = ld_data;
                    cnt_d     = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = StRun;
                        start_d = 1'b1;
                    end
                end
            end

            StRun: begin
                mem_addr = cpu_pc[ADDR_W+1:2];
                // A fetch issued alongside load_req still completes next cycle.
                ivalid_d = fetch_en;
                if (fetch_en && pc_bad) begin
                    err_d = 1'b1;
                end
                if (load_req) begin
                    state_d = StClear;
                    cnt_d   = '0;
                    len_d   = len_clamped;
                    err_d   = 1'b0;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            len_q    <= '0;
            err_q    <= 1'b0;
            ivalid_q <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            err_q    <= err_d;
            ivalid_q <= ivalid_d;
            start_q  <= start_d;
        end
    end

    assign instr_valid = ivalid_q;
    assign instr       = ivalid_q ? mem_rdata : 32'd0;
    assign cpu_start   = start_q;
    assign err         = err_q;
    assign busy        = (state_q == StClear) || (state_q == StLoad);
    assign cpu_stall   = (state_q != StRun);

endmodule
